// File: rtl/ssd_scan_rx.sv
// ssd_scan_rx: oversampling receiver for a 4-digit multiplexed seven-segment bus.
// Decodes each stable digit pattern back to BCD into per-digit registers A..D,
// flags complete frames and undecodable patterns.
// Define SSD_SCAN_RX_HEX_EN to also decode the hex letters A..F (7C then means b).
module ssd_scan_rx #(
    parameter int unsigned STABLE_CYC   = 4,
    parameter bit          SEG_ACT_HIGH = 1'b1,
    parameter bit          DG_ACT_HIGH  = 1'b1
) (
    input  logic       Clk,
    input  logic       Aclr,
    input  logic [1:4] DG,
    input  logic [7:0] seg,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [3:0] blank,
    output logic       frame_done,
    output logic       err
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_COUNT = 2'd1;
    localparam logic [1:0]  S_HELD  = 2'd2;
    localparam logic [7:0]  LAST    = 8'(STABLE_CYC - 1);
    localparam logic [10:0] INV     = {{4{~DG_ACT_HIGH}}, {7{~SEG_ACT_HIGH}}};

    logic [10:0] sync1, sync2, prev, cur;
    logic [1:0]  state, idx;
    logic [7:0]  count;
    logic [3:0]  mask, dg, dval;
    logic [6:0]  sg;
    logic [3:0]  dig [4];
    logic        changed, onehot, capture, dok, dblank, full;
    logic        dp_unused;

    assign dp_unused = seg[7];
    assign cur       = sync2 ^ INV;
    assign dg        = cur[10:7];
    assign sg        = cur[6:0];
    assign changed   = cur != prev;
    assign onehot    = $onehot(dg);
    assign capture   = state == S_COUNT && !changed && onehot && count == LAST;
    assign idx       = dg[0] ? 2'd0 : dg[1] ? 2'd1 : dg[2] ? 2'd2 : 2'd3;
    assign full      = mask == 4'hF;
    assign A         = dig[0];
    assign B         = dig[1];
    assign C         = dig[2];
    assign D         = dig[3];

    // Two-flop synchroniser on the raw pins, then a delayed copy of the corrected sample.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {DG[4], DG[3], DG[2], DG[1], seg[6:0]};
            sync2 <= sync1;
            prev  <= cur;
        end
    end

    // Stability filter: restart on any change, give up on non-one-hot strobes, hold after capture.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            state <= S_IDLE;
            count <= '0;
        end else if (changed) begin
            state <= S_COUNT;
            count <= '0;
        end else if (state == S_COUNT) begin
            if (!onehot)
                state <= S_IDLE;
            else if (count == LAST)
                state <= S_HELD;
            else
                count <= count + 8'd1;
        end
    end

    // Segment pattern (gfedcba) to digit value; all-off is a blank digit.
    always_comb begin
        dval   = 4'h0;
        dok    = 1'b1;
        dblank = 1'b0;
        case (sg)
            7'h00: dblank = 1'b1;
            7'h3F: dval = 4'h0;
            7'h06: dval = 4'h1;
            7'h5B: dval = 4'h2;
            7'h4F: dval = 4'h3;
            7'h66: dval = 4'h4;
            7'h6D: dval = 4'h5;
            7'h07: dval = 4'h7;
            7'h7F: dval = 4'h8;
            7'h6F, 7'h67: dval = 4'h9;
`ifdef SSD_SCAN_RX_HEX_EN
            7'h7D: dval = 4'h6;
            7'h77: dval = 4'hA;
            7'h7C: dval = 4'hB;
            7'h39: dval = 4'hC;
            7'h5E: dval = 4'hD;
            7'h79: dval = 4'hE;
            7'h71: dval = 4'hF;
`else
            7'h7D, 7'h7C: dval = 4'h6;
`endif
            default: dok = 1'b0;
        endcase
    end

    // Capture into the digit registers, track which digits make up the current frame.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            dig        <= '{default: 4'h0};
            blank      <= 4'hF;
            mask       <= 4'h0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= full;
            err        <= capture && !dok;
            mask       <= (full ? 4'h0 : mask) | (capture && dok ? 4'b0001 << idx : 4'h0);
            if (capture && dok) begin
                dig[idx]   <= dval;
                blank[idx] <= dblank;
            end
        end
    end
endmodule
